soc_rst_seq: RTL

SOC_RST_SEQ -- requirements
Module: soc_rst_seq

---
 rtl/soc_rst_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/soc_rst_seq.sv
// SoC reset sequencer: clock lock -> DRAM reset pulse -> calibration wait -> SoC reset hold -> run.
// Define SOC_RST_SEQ_CALIB_TIMEOUT_EN to enable calibration timeout, retry and FAIL handling.
module soc_rst_seq #(
  parameter int unsigned DramRstCycles = 16,
  parameter int unsigned CalibTimeout  = 2**22,
  parameter int unsigned MaxRetries    = 3,
  parameter int unsigned HoldCycles    = 32,
  localparam int unsigned RetryW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              locked_i,
  input  logic              calib_done_i,
  input  logic              sw_rst_req_i,
  input  logic [1:0]        boot_mode_i,
  output logic              dram_rst_o,
  output logic              soc_rst_no,
  output logic [1:0]        boot_mode_o,
  output logic              calib_fail_o,
  output logic [RetryW-1:0] retry_cnt_o,
  output logic [2:0]        state_o
);

  localparam int unsigned MaxA   = (DramRstCycles > HoldCycles) ? DramRstCycles : HoldCycles;
  localparam int unsigned MaxCnt = (MaxA > CalibTimeout) ? MaxA : CalibTimeout;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  localparam logic [CntW-1:0] DramLast = CntW'(DramRstCycles - 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
`ifdef SOC_RST_SEQ_CALIB_TIMEOUT_EN
  localparam logic [CntW-1:0] CalibLast = CntW'(CalibTimeout - 1);
`endif

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    DRAM_RST   = 3'd1,
    WAIT_CALIB = 3'd2,
    HOLD       = 3'd3,
    RUN        = 3'd4,
    FAIL       = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [1:0]        boot_q, boot_d;
  logic [2:0]        sync0_q, sync1_q;
  logic              dram_rst_q, soc_rst_q, fail_q;
  logic              lock, calib, swreq;

  assign lock  = sync1_q[0];
  assign calib = sync1_q[1];
  assign swreq = sync1_q[2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    boot_d  = boot_q;
    if (state_q != WAIT_LOCK && !lock) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        WAIT_LOCK: if (lock) begin
          state_d = DRAM_RST;
          cnt_d   = '0;
        end
        DRAM_RST: if (cnt_q == DramLast) begin
          state_d = WAIT_CALIB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        WAIT_CALIB: if (calib) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
`ifdef SOC_RST_SEQ_CALIB_TIMEOUT_EN
        else if (cnt_q == CalibLast) begin
          cnt_d = '0;
          if (retry_q < RetryW'(MaxRetries)) begin
            retry_d = retry_q + 1'b1;
            state_d = DRAM_RST;
          end else begin
            state_d = FAIL;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
        HOLD: if (swreq) begin
          cnt_d = '0;
        end else if (cnt_q == HoldLast) begin
          state_d = RUN;
          cnt_d   = '0;
          boot_d  = boot_mode_i;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        RUN: if (!calib) begin
          state_d = DRAM_RST;
          cnt_d   = '0;
        end else if (swreq) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
        FAIL: if (swreq) begin
          state_d = WAIT_LOCK;
          retry_d = '0;
        end
        default: state_d = WAIT_LOCK;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as state_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync0_q    <= '0;
      sync1_q    <= '0;
      state_q    <= WAIT_LOCK;
      cnt_q      <= '0;
      retry_q    <= '0;
      boot_q     <= '0;
      dram_rst_q <= 1'b1;
      soc_rst_q  <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      sync0_q    <= {sw_rst_req_i, calib_done_i, locked_i};
      sync1_q    <= sync0_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      boot_q     <= boot_d;
      dram_rst_q <= (state_d == WAIT_LOCK) || (state_d == DRAM_RST);
      soc_rst_q  <= (state_d == RUN);
      fail_q     <= (state_d == FAIL);
    end
  end

  // Without the timeout build, retry never increments and FAIL is unreachable,
  // so both registers collapse to constant zero.
  assign dram_rst_o   = dram_rst_q;
  assign soc_rst_no   = soc_rst_q;
  assign boot_mode_o  = boot_q;
  assign calib_fail_o = fail_q;
  assign retry_cnt_o  = retry_q;
  assign state_o      = state_q;

endmodule
